// File: rtl/frame_decoder.sv
// frame_decoder
//
// Receive-side frame reassembler. Pops bytes from a first-word-fall-through
// byte queue carrying the uplink packet stream (header {type[2:0],5'b0}, zero
// pad byte, then payload) and rebuilds each frame into a typed 12-bit sample
// on a valid/ready port. Malformed bytes are counted as framing errors and
// the decoder resynchronises by searching for the next valid header.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   in_data      head byte of the input queue (valid when em_in = 0)
//   em_in        input queue empty
//   pp_in        registered pop strobe, one cycle per consumed byte
//   out_type     frame type: 1=DIN 2=ADC0 3=ADC1 4=CADC0 5=CADC1
//   out_data     sample; DIN is zero-extended {4'h0, byte}
//   out_valid    sample available, held until out_ready handshake
//   out_ready    downstream accept
//   frame_count  good frames delivered (saturating, ERR_W bits)
//   err_count    framing errors seen (saturating, ERR_W bits)
//   err_pulse    one-cycle strobe per framing error
module frame_decoder #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             em_in,
    output logic             pp_in,
    output logic [2:0]       out_type,
    output logic [11:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ERR_W-1:0] frame_count,
    output logic [ERR_W-1:0] err_count,
    output logic             err_pulse
);

    typedef enum logic [2:0] {
        S_HDR,
        S_PAD,
        S_HI,
        S_LO,
        S_EMIT
    } state_t;

    localparam logic [ERR_W-1:0] CNT_MAX = '1;
    localparam logic [ERR_W-1:0] CNT_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    state_t     state_q, state_d;
    logic [2:0] type_q;
    logic [3:0] hi_q;
    logic       cap;
    logic       err_d;
    logic       emit_d;
    logic       lat_type;
    logic       lat_hi;

    always_comb begin
        // A byte is only taken when no pop is in flight and no sample is
        // waiting, which limits consumption to one byte every two cycles.
        cap      = !em_in && !pp_in && !out_valid && (state_q != S_EMIT);
        state_d  = state_q;
        err_d    = 1'b0;
        emit_d   = 1'b0;
        lat_type = 1'b0;
        lat_hi   = 1'b0;
        case (state_q)
            S_HDR: begin
                if (cap) begin
                    if ((in_data[7:5] >= 3'd1) && (in_data[7:5] <= 3'd5) &&
                        (in_data[4:0] == 5'd0)) begin
                        lat_type = 1'b1;
                        state_d  = S_PAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_PAD: begin
                if (cap) begin
                    if (in_data == 8'h00) begin
                        // DIN carries a single data byte, ADC types two.
                        state_d = (type_q == 3'd1) ? S_LO : S_HI;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_HDR;
                    end
                end
            end
            S_HI: begin
                if (cap) begin
                    if (in_data[7:4] == 4'h0) begin
                        lat_hi  = 1'b1;
                        state_d = S_LO;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_HDR;
                    end
                end
            end
            S_LO: begin
                if (cap) begin
                    emit_d  = 1'b1;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_valid && out_ready) begin
                    state_d = S_HDR;
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_HDR;
            pp_in       <= 1'b0;
            out_valid   <= 1'b0;
            out_type    <= 3'd0;
            out_data    <= 12'd0;
            frame_count <= '0;
            err_count   <= '0;
            err_pulse   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pp_in     <= cap;
            err_pulse <= err_d;
            if (err_d && (err_count != CNT_MAX)) begin
                err_count <= err_count + CNT_ONE;
            end
            if (emit_d) begin
                out_valid <= 1'b1;
                out_type  <= type_q;
                out_data  <= (type_q == 3'd1) ? {4'h0, in_data} : {hi_q, in_data};
                if (frame_count != CNT_MAX) begin
                    frame_count <= frame_count + CNT_ONE;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Frame-internal data latches; meaningless until the header/hi byte is taken
    always_ff @(posedge clk) begin
        if (lat_type) begin
            type_q <= in_data[7:5];
        end
        if (lat_hi) begin
            hi_q <= in_data[3:0];
        end
    end

endmodule
